sd_dma_engine: RTL
==================

# sd_dma_engine

Parametrised SD DMA engine for SD-card block transfers: SD->RAM and RAM->SD, with configurable beat width and block size. Memory side uses a valid/ready request port. The SD side uses a command/done/err handshake to the SPI SD controller. Beyond the first-generation controller, it adds asynchronous reset, an ABORT command, SD-side error reporting, a completed-block counter and an interrupt output. It sits between the MMIO register file and the SPI SD controller.

## Interface
Parameters:
- DATA_W, 32: memory beat width in bits (32 or 64).
- BLOCK_BYTES, 512: SD block size in bytes; must be a power of two.
- CNT_W, 16: width of the block count and the completed-block counter.
- Derived: WPB = BLOCK_BYTES*8/DATA_W (words per block); IDX_W = $clog2(WPB).

Ports:
- clk  in  1  sole clock. Reset is asynchronous, active-low (rst_n).
- rst_n  in  1  asynchronous active-low reset.
- mem_start_addr  in  32  RAM byte address; sampled at START.
- sd_block_start_addr  in  32  first SD block; sampled at START.
- num_blocks  in  CNT_W  block count; sampled at START.
- ctrl_data  in  32  control write data: bit0 START, bit1 DIR (1 = RAM->SD), bit2 IRQ_EN, bit3 SD_INIT, bit4 ABORT.
- ctrl_write  in  1  control write strobe.
- status_clear  in  1  clears DONE, ERR and error_code.
- mem_req_valid  out  1  memory request pending.
- mem_req_ready  in  1  memory accepts the beat.
- mem_req_write  out  1  1 = write to RAM.
- mem_req_addr  out  32  beat byte address.
- mem_req_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid in the accept cycle.
- sd_cmd_valid  out  1  SD command outstanding (level).
- sd_cmd_init  out  1  command is card init.
- sd_cmd_write  out  1  1 = write block to card.
- sd_cmd_block_addr  out  32  current SD block address.
- sd_cmd_done  in  1  one-cycle success pulse.
- sd_cmd_err  in  1  one-cycle failure pulse.
- sd_rd_block  in  BLOCK_BYTES*8  block read from the card.
- sd_rd_block_valid  in  1  sd_rd_block is valid.
- sd_wr_block  out  BLOCK_BYTES*8  staging buffer contents.
- ctrl  out  32  {27'b0, 0, 0, IRQ_EN, DIR, 0}; trigger bits read as 0.
- status  out  32  {28'b0, INITED, ERR, DONE, BUSY}.
- error_code  out  32  sticky error code.
- blocks_done  out  CNT_W  blocks completed in the current or last transfer.
- irq  out  1  equals DONE && IRQ_EN (level).

## Operation
- States: IDLE, INIT_WAIT, SD_FETCH, MEM_WR, MEM_RD, SD_STORE.
- Error codes: 1 BUSY, 2 ZERO_LEN, 3 NOT_INIT, 4 SD_FAIL, 5 ABORTED.
- Command priority on ctrl_write: ABORT > SD_INIT > START. DIR and IRQ_EN load on every ctrl write.
- ABORT while not IDLE: go to IDLE with BUSY=0, DONE=1, ERR=1, code 5. ABORT in IDLE: no-op.
- SD_INIT or START while busy: ERR=1, code 1. State, DONE and the transfer are unchanged.
- SD_INIT from IDLE: clear DONE, ERR and code; go to INIT_WAIT.
  - On sd_cmd_done: INITED=1, DONE=1, go to IDLE.
  - On sd_cmd_err: INITED=0, DONE=1, ERR=1, code 4, go to IDLE.
- START from IDLE:
  - If INITED=0: DONE=1, ERR=1, code 3.
  - Else if num_blocks==0: DONE=1, ERR=1, code 2.
  - Else: latch the parameters, clear blocks_done, clear DONE, ERR and code. Go to SD_FETCH (DIR=0) or MEM_RD (DIR=1).
- SD_FETCH: sd_cmd_valid=1, sd_cmd_write=0.
  - sd_rd_block_valid loads the buffer; it may arrive in the same cycle as sd_cmd_done.
  - On sd_cmd_done: go to MEM_WR.
- MEM_WR: issues WPB write beats. mem_req_wdata = buffer word[idx].
- MEM_RD: issues WPB read beats; buffer word[idx] <= mem_rdata on accept.
- SD_STORE: sd_cmd_valid=1, sd_cmd_write=1; on sd_cmd_done, go to the next block or finish.
- Block completes when its last beat is accepted (SD->RAM) or on sd_cmd_done in SD_STORE (RAM->SD). At that edge: blocks_done+1, block offset+1. Then:
  - If this was the last block: DONE=1, go to IDLE.
  - Else go back to SD_FETCH (SD->RAM) or MEM_RD (RAM->SD).
- sd_cmd_err in SD_FETCH or SD_STORE: DONE=1, ERR=1, code 4, go to IDLE.
- sd_cmd_done or sd_cmd_err outside INIT_WAIT, SD_FETCH and SD_STORE is ignored.
- sd_cmd_block_addr = start + offset, 32-bit wrap.
- mem_req_addr advances by DATA_W/8 per beat, 32-bit wrap.
- idx wraps from WPB-1 to 0 at each block.

## Timing
- Reset values: every output and register 0, including INITED, buffer, ctrl, status, error_code, blocks_done and irq.
- Registered FSM: mem_req_valid or sd_cmd_valid rises on the cycle after the START or SD_INIT write edge.
- Beat transfers when mem_req_valid && mem_req_ready. Address and idx update at that edge, so back-to-back beats are sustained at 1 per cycle.
- mem_req_valid drops on the cycle after the last beat of a block is accepted.
- sd_cmd_valid deasserts on the cycle after sd_cmd_done or sd_cmd_err.
- status_clear in the same cycle as an event that sets DONE or ERR: the set wins.
- ABORT in the same cycle as a final sd_cmd_done or final beat: ABORT wins (code 5).
- Reset mid-transfer: immediate return to IDLE; INITED is cleared.

## Structure
- sd_dma_pkg:
  - state enum
  - error-code constants
  - ctrl bit indices
  - status bit indices
- Sub-module sd_dma_block_buffer: WPB x DATA_W staging buffer. Provides a full-block parallel load, a single-word write at idx, a single-word read at idx, and a flat output.

## Test plan
- START before init -> next cycle status=0x6, error_code=3, no mem or sd requests.
- SD_INIT, then sd_cmd_done 5 cycles later -> status=0xA, irq=0 (IRQ_EN=0).
- Init, then DIR=0, num_blocks=2, mem_start_addr=0x1000 with ready stuck at 1 -> 2 SD_FETCH commands to blocks S and S+1, 256 beats at 0x1000..0x13FC (DATA_W=32), blocks_done=2, DONE=1.
- DIR=1, 1 block with mem_req_ready toggling -> sd_wr_block equals the 128 words read, then SD_STORE; DONE only after sd_cmd_done.
- ABORT during the second MEM_WR block -> next cycle BUSY=0, error_code=5, blocks_done=1, mem_req_valid=0; a late sd_cmd_done is ignored.
- sd_cmd_err in SD_STORE -> error_code=4, INITED still 1; rst_n low mid-transfer -> all outputs 0.

Source files
------------

// File: rtl/sd_dma_pkg.sv
// Shared types and constants for the SD DMA engine: FSM states, error codes,
// and the bit positions of the control and status registers.
package sd_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_WAIT,
        ST_SD_FETCH,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_SD_STORE
    } state_e;

    localparam logic [31:0] ERR_BUSY     = 32'd1;
    localparam logic [31:0] ERR_ZERO_LEN = 32'd2;
    localparam logic [31:0] ERR_NOT_INIT = 32'd3;
    localparam logic [31:0] ERR_SD_FAIL  = 32'd4;
    localparam logic [31:0] ERR_ABORTED  = 32'd5;

    localparam int CTRL_START   = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_SD_INIT = 3;
    localparam int CTRL_ABORT   = 4;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_ERR    = 2;
    localparam int STAT_INITED = 3;

endpackage

// File: rtl/sd_dma_if.sv
// Memory request port of the SD DMA engine. valid/ready: a beat transfers on
// any edge where valid && ready; the master holds addr/write/wdata stable while
// valid is high and not yet accepted, and read data is valid in the accept cycle.
interface sd_dma_if #(
    parameter int DATA_W = 32
) ();
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [31:0]       mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rdata
    );
endinterface

// File: rtl/sd_dma_block_buffer.sv
// One-block staging buffer, WPB words of DATA_W. Word i lives at bits
// [i*DATA_W +: DATA_W] of the flat view, matching the SD block bus layout.
module sd_dma_block_buffer #(
    parameter int DATA_W = 32,
    parameter int WPB    = 128,
    parameter int IDX_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_all,
    input  logic [WPB*DATA_W-1:0] load_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data,
    output logic [WPB*DATA_W-1:0] flat
);
    logic [WPB*DATA_W-1:0] buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (load_all) begin
            buf_q <= load_data;
        end else if (wr_en) begin
            buf_q[int'(idx)*DATA_W +: DATA_W] <= wr_data;
        end
    end

    assign rd_data = buf_q[int'(idx)*DATA_W +: DATA_W];
    assign flat    = buf_q;
endmodule

// File: rtl/sd_dma_engine.sv
// SD DMA engine: moves whole SD blocks between the SPI SD controller and RAM
// through a one-block staging buffer, with init, abort, error codes and irq.
module sd_dma_engine
    import sd_dma_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BLOCK_BYTES = 512,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              mem_start_addr,
    input  logic [31:0]              sd_block_start_addr,
    input  logic [CNT_W-1:0]         num_blocks,
    input  logic [31:0]              ctrl_data,
    input  logic                     ctrl_write,
    input  logic                     status_clear,
    sd_dma_if.master                 mem,
    output logic                     sd_cmd_valid,
    output logic                     sd_cmd_init,
    output logic                     sd_cmd_write,
    output logic [31:0]              sd_cmd_block_addr,
    input  logic                     sd_cmd_done,
    input  logic                     sd_cmd_err,
    input  logic [BLOCK_BYTES*8-1:0] sd_rd_block,
    input  logic                     sd_rd_block_valid,
    output logic [BLOCK_BYTES*8-1:0] sd_wr_block,
    output logic [31:0]              ctrl,
    output logic [31:0]              status,
    output logic [31:0]              error_code,
    output logic [CNT_W-1:0]         blocks_done,
    output logic                     irq,
    output state_e                   dbg_state
);
    localparam int              WPB        = BLOCK_BYTES * 8 / DATA_W;
    localparam int              IDX_W      = $clog2(WPB);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WPB - 1);
    localparam logic [31:0]     BEAT_BYTES = 32'(DATA_W / 8);

    state_e            state_q, state_d;
    logic              inited_q, inited_d, done_q, done_d, err_q, err_d;
    logic              irq_en_q, irq_en_d, dir_q, dir_d;
    logic [31:0]       code_q, code_d, sd_base_q, sd_base_d, mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  blocks_done_q, blocks_done_d, nblk_q, nblk_d, blocks_next;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              buf_load, buf_wr, beat, last_beat, last_block;
    logic              cmd_abort, cmd_init, cmd_start;
    logic [DATA_W-1:0] buf_rd;
    logic [26:0]       unused_ctrl_bits;

    assign unused_ctrl_bits = ctrl_data[31:5];

    // ABORT outranks SD_INIT, which outranks START, within a single write.
    assign cmd_abort = ctrl_write && ctrl_data[CTRL_ABORT];
    assign cmd_init  = ctrl_write && ctrl_data[CTRL_SD_INIT] && !cmd_abort;
    assign cmd_start = ctrl_write && ctrl_data[CTRL_START] && !cmd_abort && !ctrl_data[CTRL_SD_INIT];

    assign beat        = mem.mem_req_valid && mem.mem_req_ready;
    assign last_beat   = beat && (idx_q == IDX_LAST);
    assign blocks_next = blocks_done_q + CNT_W'(1);
    assign last_block  = (blocks_next == nblk_q);

    always_comb begin
        state_d       = state_q;
        inited_d      = inited_q;
        done_d        = done_q;
        err_d         = err_q;
        code_d        = code_q;
        irq_en_d      = irq_en_q;
        dir_d         = dir_q;
        blocks_done_d = blocks_done_q;
        nblk_d        = nblk_q;
        sd_base_d     = sd_base_q;
        mem_addr_d    = mem_addr_q;
        idx_d         = idx_q;
        buf_load      = 1'b0;
        buf_wr        = 1'b0;

        if (ctrl_write) begin
            dir_d    = ctrl_data[CTRL_DIR];
            irq_en_d = ctrl_data[CTRL_IRQ_EN];
        end
        // Clear first so any same-cycle set below wins.
        if (status_clear) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            code_d = '0;
        end

        if (cmd_abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            code_d  = ERR_ABORTED;
        end else begin
            if ((cmd_init || cmd_start) && state_q != ST_IDLE) begin
                err_d  = 1'b1;
                code_d = ERR_BUSY;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_init) begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        code_d  = '0;
                        state_d = ST_INIT_WAIT;
                    end else if (cmd_start) begin
                        if (!inited_q) begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                            code_d = ERR_NOT_INIT;
                        end else if (num_blocks == '0) begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                            code_d = ERR_ZERO_LEN;
                        end else begin
                            mem_addr_d    = mem_start_addr;
                            sd_base_d     = sd_block_start_addr;
                            nblk_d        = num_blocks;
                            blocks_done_d = '0;
                            idx_d         = '0;
                            done_d        = 1'b0;
                            err_d         = 1'b0;
                            code_d        = '0;
                            state_d       = ctrl_data[CTRL_DIR] ? ST_MEM_RD : ST_SD_FETCH;
                        end
                    end
                end
                ST_INIT_WAIT: begin
                    if (sd_cmd_err) begin
                        inited_d = 1'b0;
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        code_d   = ERR_SD_FAIL;
                        state_d  = ST_IDLE;
                    end else if (sd_cmd_done) begin
                        inited_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_SD_FETCH: begin
                    buf_load = sd_rd_block_valid;
                    if (sd_cmd_err) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        code_d  = ERR_SD_FAIL;
                        state_d = ST_IDLE;
                    end else if (sd_cmd_done) begin
                        state_d = ST_MEM_WR;
                    end
                end
                ST_MEM_WR, ST_MEM_RD: begin
                    buf_wr = beat && (state_q == ST_MEM_RD);
                    if (beat) begin
                        mem_addr_d = mem_addr_q + BEAT_BYTES;
                        idx_d      = idx_q + IDX_W'(1);
                    end
                    if (last_beat && state_q == ST_MEM_RD) begin
                        state_d = ST_SD_STORE;
                    end else if (last_beat) begin
                        blocks_done_d = blocks_next;
                        if (last_block) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_SD_FETCH;
                        end
                    end
                end
                ST_SD_STORE: begin
                    if (sd_cmd_err) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        code_d  = ERR_SD_FAIL;
                        state_d = ST_IDLE;
                    end else if (sd_cmd_done) begin
                        blocks_done_d = blocks_next;
                        if (last_block) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_MEM_RD;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            inited_q      <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            code_q        <= '0;
            irq_en_q      <= 1'b0;
            dir_q         <= 1'b0;
            blocks_done_q <= '0;
            nblk_q        <= '0;
            sd_base_q     <= '0;
            mem_addr_q    <= '0;
            idx_q         <= '0;
        end else begin
            state_q       <= state_d;
            inited_q      <= inited_d;
            done_q        <= done_d;
            err_q         <= err_d;
            code_q        <= code_d;
            irq_en_q      <= irq_en_d;
            dir_q         <= dir_d;
            blocks_done_q <= blocks_done_d;
            nblk_q        <= nblk_d;
            sd_base_q     <= sd_base_d;
            mem_addr_q    <= mem_addr_d;
            idx_q         <= idx_d;
        end
    end

    sd_dma_block_buffer #(.DATA_W(DATA_W), .WPB(WPB), .IDX_W(IDX_W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_all  (buf_load),
        .load_data (sd_rd_block),
        .wr_en     (buf_wr),
        .idx       (idx_q),
        .wr_data   (mem.mem_rdata),
        .rd_data   (buf_rd),
        .flat      (sd_wr_block)
    );

    assign mem.mem_req_valid = (state_q == ST_MEM_WR) || (state_q == ST_MEM_RD);
    assign mem.mem_req_write = (state_q == ST_MEM_WR);
    assign mem.mem_req_addr  = mem_addr_q;
    assign mem.mem_req_wdata = buf_rd;

    assign sd_cmd_valid      = (state_q == ST_INIT_WAIT) || (state_q == ST_SD_FETCH) || (state_q == ST_SD_STORE);
    assign sd_cmd_init       = (state_q == ST_INIT_WAIT);
    assign sd_cmd_write      = (state_q == ST_SD_STORE);
    assign sd_cmd_block_addr = sd_base_q + 32'(blocks_done_q);

    assign ctrl        = {27'b0, 1'b0, 1'b0, irq_en_q, dir_q, 1'b0};
    assign status      = {28'b0, inited_q, err_q, done_q, state_q != ST_IDLE};
    assign error_code  = code_q;
    assign blocks_done = blocks_done_q;
    assign irq         = done_q && irq_en_q;
    assign dbg_state   = state_q;
endmodule
